// File: rtl/parity_serializer_pkg.sv
// parity_serializer_pkg
//   Shared definitions for the framed parity serializer:
//   - state_e     : transmitter FSM states
//   - frame_bits  : number of bit slots in one frame (start + W data + parity + stop)
//   - LINE_IDLE   : level of the serial line while idle and during the stop bit
package parity_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int frame_bits(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/parity_generator.sv
// parity_generator
//   Combinational even-parity generator: parity = XOR of all data bits.
//   Ports:
//     in_data  in  [W-1:0]  data word
//     parity   out          even parity of in_data
module parity_generator #(
  parameter int W = 16
) (
  input  logic [W-1:0] in_data,
  output logic         parity
);

  assign parity = ^in_data;

endmodule

// File: rtl/parity_serializer.sv
// parity_serializer
//   Framed serial transmitter. Accepts a W-bit word over valid/ready and
//   sends start(0), W data bits LSB first, parity, stop(1), each bit held
//   CLKS_PER_BIT clocks. tx is registered and idles high.
//   Build option: define PARITY_SERIALIZER_ODD_EN for odd parity
//   (default is even parity, taken straight from parity_generator).
//   Ports:
//     clk         in            rising-edge clock
//     rst         in            asynchronous active-high reset
//     in_valid    in            in_data valid
//     in_data     in  [W-1:0]   word to transmit
//     in_ready    out           word can be accepted (FSM in IDLE)
//     tx          out           serial line
//     busy        out           frame in progress
//     frame_done  out           pulse on the last cycle of the stop bit
module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int W            = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(W);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(W - 1);

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [W-1:0]        shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;

  logic gen_parity;
  logic parity_sel;
  logic accept;
  logic baud_last;
  logic bit_last;

  parity_generator #(.W(W)) u_parity_generator (
    .in_data (in_data),
    .parity  (gen_parity)
  );

`ifdef PARITY_SERIALIZER_ODD_EN
  assign parity_sel = ~gen_parity;
`else
  assign parity_sel = gen_parity;
`endif

  assign baud_last = (baud_q == BAUD_MAX);
  assign bit_last  = (bit_q == BIT_MAX);
  assign accept    = in_valid && in_ready;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever the statement order.
  // NOTE: the shift register and parity flop are reset too; they are tiny and
  // a defined value keeps tx deterministic straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                state_d = START;
      START:   if (baud_last)             state_d = DATA;
      DATA:    if (baud_last && bit_last) state_d = PARITY;
      PARITY:  if (baud_last)             state_d = STOP;
      STOP:    if (baud_last)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Datapath: counters, shift register, parity latch and next line level.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;

    if (state_q == IDLE) begin
      baud_d = '0;
      bit_d  = '0;
      if (accept) begin
        shreg_d  = in_data;
        parity_d = parity_sel;
      end
    end else begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
      if (state_q == DATA && baud_last) begin
        bit_d   = bit_last ? '0 : bit_q + 1'b1;
        shreg_d = shreg_q >> 1;
      end
    end

    // tx is registered, so its next value follows the state being entered;
    // this makes tx fall on the acceptance edge itself.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = LINE_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      STOP:    frame_done = baud_last;
      default: ;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer
//   Self-checking bench. Instance a uses W=16, CLKS_PER_BIT=4 for the directed
//   table, back-to-back and reset cases; instance b uses CLKS_PER_BIT=1 for the
//   1000-word random run. A bench deserializer samples every bit mid-slot.
//   Works in both builds (PARITY_SERIALIZER_ODD_EN defined or not).
module tb_parity_serializer;
  import parity_serializer_pkg::*;

`ifdef PARITY_SERIALIZER_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        use_fast = 1'b0;

  logic in_valid_a, in_ready_a, tx_a, busy_a, frame_done_a;
  logic in_valid_b, in_ready_b, tx_b, busy_b, frame_done_b;
  logic m_tx, m_in_ready, m_busy, m_frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign in_valid_a   = in_valid & ~use_fast;
  assign in_valid_b   = in_valid & use_fast;
  assign m_tx         = use_fast ? tx_b         : tx_a;
  assign m_in_ready   = use_fast ? in_ready_b   : in_ready_a;
  assign m_busy       = use_fast ? busy_b       : busy_a;
  assign m_frame_done = use_fast ? frame_done_b : frame_done_a;

  parity_serializer #(.W(16), .CLKS_PER_BIT(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_a),
    .in_data    (in_data),
    .in_ready   (in_ready_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .frame_done (frame_done_a)
  );

  parity_serializer #(.W(16), .CLKS_PER_BIT(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_b),
    .in_data    (in_data),
    .in_ready   (in_ready_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .frame_done (frame_done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample point and stimulus point: the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic ref_par(input logic [15:0] d);
    return (^d) ^ ODD;
  endfunction

  // Offer a word and wait (bounded) for acceptance. Returns at cycle 0 of the
  // frame, i.e. the first sample after the acceptance edge. in_data is then
  // replaced by after_data to show the frame in flight ignores it.
  task automatic start_word(input logic [15:0] d, input logic hold, input logic [15:0] after_data);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (m_in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("accept_wait", {31'd0, n < 200}, 32'd1);
    tick();
    check("accept_tx_low", {31'd0, m_tx}, 32'd0);
    if (!hold) in_valid = 1'b0;
    in_data = after_data;
  endtask

  // Follow one frame from cycle 0 through its last cycle, then step one more
  // cycle into IDLE. frame_done must mark the last of the frame's cycles.
  task automatic run_frame(input logic [15:0] d, input logic exp_par, input int cpb);
    int   cycles = frame_bits(16) * cpb;
    int   tx_err = 0, hs_err = 0, fd_cnt = 0, fd_pos = -1;
    logic [15:0] rx = '0;
    logic rx_par = 1'bx;
    logic exp_tx;
    for (int c = 0; c < cycles; c++) begin
      int k = c / cpb;
      if (k == 0)       exp_tx = 1'b0;
      else if (k <= 16) exp_tx = d[k-1];
      else if (k == 17) exp_tx = exp_par;
      else              exp_tx = 1'b1;
      if (m_tx !== exp_tx) tx_err++;
      if (c % cpb == cpb / 2) begin
        if (k >= 1 && k <= 16) rx[k-1] = m_tx;
        if (k == 17)           rx_par  = m_tx;
      end
      if (m_in_ready !== 1'b0 || m_busy !== 1'b1) hs_err++;
      if (m_frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = c;
      end
      if (c < cycles - 1) tick();
    end
    check("tx_pattern_errs", tx_err, 0);
    check("rx_word", {16'd0, rx}, {16'd0, d});
    check("rx_parity", {31'd0, rx_par}, {31'd0, exp_par});
    check("handshake_errs", hs_err, 0);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_cycle", fd_pos, cycles - 1);
    tick();
    check("post_idle", {28'd0, m_tx, m_in_ready, m_busy, m_frame_done}, 32'b1100);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        even_par;
    int          gap;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h0001, 1'b1, 0};
    vecs[1] = '{16'h0003, 1'b0, 1};
    vecs[2] = '{16'h8000, 1'b1, 0};
    vecs[3] = '{16'hFFFF, 1'b0, 3};
    vecs[4] = '{16'hA5A5, 1'b0, 0};
    vecs[5] = '{16'h0000, 1'b0, 2};
    vecs[6] = '{16'h7FFF, 1'b1, 0};
    vecs[7] = '{16'h1234, 1'b1, 5};

    // Reset and idle.
    tick();
    check("in_reset", {28'd0, tx_a, in_ready_a, busy_a, frame_done_a}, 32'b1100);
    tick();
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_tx", {31'd0, tx_a}, 32'd1);
      check("idle_ready", {31'd0, in_ready_a}, 32'd1);
      check("idle_busy", {31'd0, busy_a}, 32'd0);
      check("idle_done", {31'd0, frame_done_a}, 32'd0);
    end

    // Table of single frames with hand-computed parity.
    foreach (vecs[i]) begin
      repeat (vecs[i].gap) tick();
      start_word(vecs[i].data, 1'b0, ~vecs[i].data);
      run_frame(vecs[i].data, vecs[i].even_par ^ ODD, 4);
    end

    // Back-to-back with in_valid held: second START 77 cycles after the first.
    start_word(16'h0003, 1'b1, 16'hFFFF);
    run_frame(16'h0003, 1'b0 ^ ODD, 4);
    tick();
    check("b2b_start_at_77", {30'd0, m_tx, m_in_ready}, 32'b00);
    in_valid = 1'b0;
    in_data  = 16'h0000;
    run_frame(16'hFFFF, 1'b0 ^ ODD, 4);

    // Reset in cycle 30 of a frame.
    start_word(16'hA5A5, 1'b0, 16'h5A5A);
    repeat (30) tick();
    check("midframe_busy", {31'd0, busy_a}, 32'd1);
    #1 rst = 1'b1;
    #1 check("rst_async", {28'd0, tx_a, in_ready_a, busy_a, frame_done_a}, 32'b1100);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", {30'd0, tx_a, frame_done_a}, 32'b10);
    end
    in_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    check("rst_release_idle", {29'd0, tx_a, in_ready_a, busy_a}, 32'b110);
    start_word(16'h0001, 1'b0, 16'hFFFE);
    run_frame(16'h0001, 1'b1 ^ ODD, 4);

    // Random words with random gaps on the CLKS_PER_BIT=1 instance.
    use_fast = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] d;
      repeat ($urandom_range(0, 3)) tick();
      d = 16'($urandom);
      start_word(d, 1'b0, ~d);
      run_frame(d, ref_par(d), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
